reg_bank_reader: RTL and testbench

//   Read-side sequencer for a bank of NREG output-enabled W-bit registers sharing one bus.
//   - Drives each register's active-low OE in turn and samples the shared bus.
//   - Assembles all NREG words into one parallel snapshot, then pulses VALID.
//   - Sits between the register bank and the consumer; guarantees at most one OE low at any time.

---
 rtl/reg_bank_pkg.sv | 10 +
 rtl/oe_decoder.sv | 15 +
 rtl/reg_bank_reader.sv | 86 ++++++++
 tb/tb_reg_bank_reader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared state encoding and sizing helpers for the register bank logic
package reg_bank_pkg;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ENABLE = 2'd1;
   localparam logic [1:0] S_GAP    = 2'd2;
   localparam int CNT_W = 3;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/oe_decoder.sv
// oe_decoder: registered active-low one-hot output-enable decode
module oe_decoder #(
   parameter int NREG  = 4,
   parameter int IDX_W = 2
) (
   input  logic             CLK,
   input  logic             CLR_N,
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [NREG-1:0]  OE_N
);
   // at most one enable low; all high when disabled or in reset
   always_ff @(posedge CLK)
      OE_N <= (!CLR_N || !en) ? '1 : ~(NREG'(1) << idx);
endmodule

// File: rtl/reg_bank_reader.sv
// reg_bank_reader: scans a shared-bus register bank and publishes a parallel snapshot
module reg_bank_reader
   import reg_bank_pkg::*;
#(
   parameter int NREG   = 4,
   parameter int W      = 4,
   parameter int SETTLE = 1
) (
   input  logic            CLK,
   input  logic            CLR_N,
   input  logic            START,
   input  logic [W-1:0]    BUS,
   output logic [NREG-1:0] OE_N,
   output logic [NREG*W-1:0] Q,
   output logic            BUSY,
   output logic            VALID
);
   localparam int IDX_W = idx_w(NREG);
   logic [1:0]       state, state_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [NREG*W-1:0] shadow;
   logic             last_en, last_idx, done, oe_en;
   // state register
   always_ff @(posedge CLK) begin
      if (!CLR_N) begin
         state <= S_IDLE;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
      end
   end
   // next state: ENABLE for SETTLE+1 cycles, then one GAP cycle per register
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      case (state)
         S_IDLE: if (START) begin
            state_nx = S_ENABLE;
            idx_nx   = '0;
            cnt_nx   = '0;
         end
         S_ENABLE: begin
            state_nx = last_en ? S_GAP : S_ENABLE;
            cnt_nx   = last_en ? '0 : cnt + CNT_W'(1);
         end
         S_GAP: begin
            state_nx = last_idx ? S_IDLE : S_ENABLE;
            idx_nx   = last_idx ? idx : idx + IDX_W'(1);
         end
         default: state_nx = S_IDLE;
      endcase
   end
   // decoded controls; the OE register is fed from next-state so it lines up with ENABLE
   always_comb begin
      last_en  = (state == S_ENABLE) && (cnt == CNT_W'(SETTLE));
      last_idx = idx == IDX_W'(NREG - 1);
      done     = (state == S_GAP) && last_idx;
      oe_en    = state_nx == S_ENABLE;
   end
   oe_decoder #(.NREG(NREG), .IDX_W(IDX_W)) u_oe (
      .CLK  (CLK),
      .CLR_N(CLR_N),
      .idx  (idx_nx),
      .en   (oe_en),
      .OE_N (OE_N)
   );
   // capture each word into shadow; publish the whole snapshot only when the scan completes
   always_ff @(posedge CLK) begin
      if (!CLR_N) begin
         shadow <= '0;
         Q      <= '0;
         BUSY   <= 1'b0;
         VALID  <= 1'b0;
      end else begin
         if (last_en) shadow[idx*W +: W] <= BUS;
         if (done) Q <= shadow;
         VALID <= done;
         BUSY  <= state_nx != S_IDLE;
      end
   end
endmodule

// File: tb/tb_reg_bank_reader.sv
// tb_reg_bank_reader: directed stimulus with a cycle-position model of the scan
module tb_reg_bank_reader;
   logic clk = 1'b0, clr_n = 1'b0, start = 1'b0;
   logic [3:0] bus0, bus1, oe0;
   logic [1:0] oe1;
   logic [15:0] q0;
   logic [7:0] q1;
   logic busy0, valid0, busy1, valid1;
   logic [3:0] bank [2][16];
   int errors = 0, checks = 0, cyc = 0, a = 0;
   bit chk_on = 1'b0;
   int nr [2] = '{4, 2};
   int st [2] = '{1, 0};
   int p [2] = '{-1, -1};
   logic [3:0] sh [2][16];
   logic [63:0] mq [2];
   logic [15:0] moe [2];
   logic mvalid [2], mbusy [2];
   int last_low [2] = '{-1, -1};
   bit seen_hi [2] = '{1'b1, 1'b1};
   int vc0 [$], vc1 [$];
   logic [15:0] vd0 [$];
   logic [7:0] vd1 [$];
   logic [3:0] exp_seq [6] = '{4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hF};

   always #5 clk = ~clk;

   reg_bank_reader #(.NREG(4), .W(4), .SETTLE(1)) u0 (
      .CLK(clk), .CLR_N(clr_n), .START(start), .BUS(bus0),
      .OE_N(oe0), .Q(q0), .BUSY(busy0), .VALID(valid0));
   reg_bank_reader #(.NREG(2), .W(4), .SETTLE(0)) u1 (
      .CLK(clk), .CLR_N(clr_n), .START(start), .BUS(bus1),
      .OE_N(oe1), .Q(q1), .BUSY(busy1), .VALID(valid1));

   // the bank: only the register whose OE is low drives the bus
   always_comb begin
      bus0 = 'z;
      bus1 = 'z;
      for (int i = 0; i < 4; i++) if (!oe0[i]) bus0 = bank[0][i];
      for (int i = 0; i < 2; i++) if (!oe1[i]) bus1 = bank[1][i];
   end

   always @(posedge clk) cyc <= cyc + 1;

   // model: p = cycles since the scan was accepted; register p/per is enabled while p%per <= SETTLE
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         mvalid[k] = 1'b0;
         if (!clr_n) begin
            p[k] = -1;
            mq[k] = '0;
            for (int i = 0; i < 16; i++) sh[k][i] = '0;
         end else if (p[k] < 0) begin
            if (start) p[k] = 0;
         end else begin
            if (p[k] % (st[k] + 2) == st[k]) sh[k][p[k] / (st[k] + 2)] = bank[k][p[k] / (st[k] + 2)];
            p[k]++;
            if (p[k] == nr[k] * (st[k] + 2)) begin
               mvalid[k] = 1'b1;
               p[k] = -1;
               for (int i = 0; i < nr[k]; i++) mq[k][i*4 +: 4] = sh[k][i];
            end
         end
         moe[k] = '1;
         if (p[k] >= 0 && p[k] % (st[k] + 2) <= st[k]) moe[k][p[k] / (st[k] + 2)] = 1'b0;
         mbusy[k] = p[k] >= 0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
      end
   endtask

   // per-cycle compare against the model, plus OE exclusivity and turnaround gaps
   always @(negedge clk) begin
      if (chk_on) begin
         logic [15:0] lo [2];
         int cur;
         chk("oe0", {12'hFFF, oe0}, moe[0]);
         chk("q0", q0, mq[0]);
         chk("busy0", busy0, mbusy[0]);
         chk("valid0", valid0, mvalid[0]);
         chk("oe1", {14'h3FFF, oe1}, moe[1]);
         chk("q1", q1, mq[1]);
         chk("busy1", busy1, mbusy[1]);
         chk("valid1", valid1, mvalid[1]);
         lo[0] = {12'h0, ~oe0};
         lo[1] = {14'h0, ~oe1};
         for (int k = 0; k < 2; k++) begin
            chk("excl", $countones(lo[k]) <= 1, 1);
            if ($countones(lo[k]) == 1) begin
               cur = $clog2(lo[k]);
               if (last_low[k] >= 0 && cur != last_low[k]) chk("gap", seen_hi[k], 1);
               last_low[k] = cur;
               seen_hi[k] = 1'b0;
            end else if (lo[k] == 0) seen_hi[k] = 1'b1;
         end
      end
      if (valid0) begin vc0.push_back(cyc); vd0.push_back(q0); end
      if (valid1) begin vc1.push_back(cyc); vd1.push_back(q1); end
   end

   task automatic clear_q();
      vc0.delete(); vd0.delete(); vc1.delete(); vd1.delete();
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      a = cyc;
   endtask

   task automatic set_bank0(input logic [15:0] v);
      for (int i = 0; i < 4; i++) bank[0][i] = v[i*4 +: 4];
   endtask

   initial begin
      for (int k = 0; k < 2; k++) for (int i = 0; i < 16; i++) bank[k][i] = '0;
      set_bank0(16'hF5A3);
      bank[1][0] = 4'h6;
      bank[1][1] = 4'h9;
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      chk("rst_oe", oe0, 4'hF);
      chk("rst_q", q0, 16'h0);
      chk("rst_busy", busy0, 0);
      chk("rst_valid", valid0, 0);
      clr_n = 1'b1;
      repeat (2) @(negedge clk);
      // basic scan, plus the 2-register SETTLE=0 instance
      clear_q();
      pulse_start();
      for (int j = 0; j < 6; j++) begin
         chk("oe_seq", oe0, exp_seq[j]);
         @(negedge clk);
      end
      repeat (14) @(negedge clk);
      chk("basic_nvalid", vc0.size(), 1);
      chk("basic_lat", (vc0.size() > 0) ? vc0[0] - a : -1, 12);
      chk("basic_q", (vd0.size() > 0) ? vd0[0] : 16'hxxxx, 16'hF5A3);
      chk("s0_nvalid", vc1.size(), 1);
      chk("s0_lat", (vc1.size() > 0) ? vc1[0] - a : -1, 4);
      chk("s0_q", (vd1.size() > 0) ? vd1[0] : 8'hxx, 8'h96);
      // START while busy is ignored
      clear_q();
      pulse_start();
      for (int j = 0; j <= 12; j++) begin
         chk("busy_win", busy0, j < 12);
         start = (j == 4);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("busy_nvalid", vc0.size(), 1);
      chk("busy_lat", (vc0.size() > 0) ? vc0[0] - a : -1, 12);
      // back-to-back with START held
      clear_q();
      @(negedge clk) start = 1'b1;
      @(negedge clk) a = cyc;
      repeat (12) @(negedge clk);
      set_bank0(16'h1000);
      repeat (14) @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      chk("b2b_n", vc0.size(), 3);
      chk("b2b_t0", (vc0.size() > 1) ? vc0[0] - a : -1, 12);
      chk("b2b_t1", (vc0.size() > 1) ? vc0[1] - a : -1, 25);
      chk("b2b_q0", (vd0.size() > 1) ? vd0[0] : 16'hxxxx, 16'hF5A3);
      chk("b2b_q1", (vd0.size() > 1) ? vd0[1] : 16'hxxxx, 16'h1000);
      // reset in the middle of a scan
      set_bank0(16'hF5A3);
      clear_q();
      pulse_start();
      repeat (6) @(negedge clk);
      chk("mid_oe", oe0, 4'b1011);
      clr_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_oe", oe0, 4'hF);
      chk("mid_rst_q", q0, 16'h0);
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_valid", valid0, 0);
      clr_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_no_valid", vc0.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
